// File: rtl/apu_rom_loader.sv
// Framed byte-stream loader for the 1 KiB APU program RAM.
// It parses the header, writes the payload, checks the XOR sum and gates APU CPU reset.
module apu_rom_loader #(
    parameter logic [7:0] START_BYTE = 8'hA5,
    parameter int         MAX_LEN    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_stb,
    input  logic [7:0] in_byte,
    output logic       ram_we,
    output logic [9:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_SUM
    } state_t;

    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

    state_t      state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic [2:0]  len_h_q, len_h_d;
    logic [10:0] count_q, count_d;
    logic [7:0]  sum_q, sum_d;
    logic        ram_we_q, ram_we_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  ram_wdata_q, ram_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [10:0] len_full;
    assign len_full = {len_h_q, in_byte};

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a latch behind.
        state_d     = state_q;
        addr_d      = addr_q;
        len_h_d     = len_h_q;
        count_d     = count_q;
        sum_d       = sum_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = 1'b0;
        error_d     = error_q;

        if (in_stb) begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_byte == START_BYTE) begin
                        state_d    = S_ADDR_H;
                        error_d    = 1'b0;
                        cpu_hold_d = 1'b1;
                        sum_d      = 8'h00;
                    end
                end
                S_ADDR_H: begin
                    addr_d  = {in_byte[1:0], addr_q[7:0]};
                    state_d = S_ADDR_L;
                end
                S_ADDR_L: begin
                    addr_d  = {addr_q[9:8], in_byte};
                    state_d = S_LEN_H;
                end
                S_LEN_H: begin
                    len_h_d = in_byte[2:0];
                    state_d = S_LEN_L;
                end
                S_LEN_L: begin
                    if (len_full == 11'd0 || len_full > MAX_LEN_W) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        count_d = len_full;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = addr_q;
                    ram_wdata_d = in_byte;
                    addr_d      = addr_q + 10'd1;  // natural 10-bit wrap 0x3FF -> 0x000
                    sum_d       = sum_q ^ in_byte;
                    count_d     = count_q - 11'd1;
                    if (count_q == 11'd1) state_d = S_SUM;
                end
                S_SUM: begin
                    if (in_byte == sum_q) begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignment so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 10'd0;
            len_h_q     <= 3'd0;
            count_q     <= 11'd0;
            sum_q       <= 8'h00;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 10'd0;
            ram_wdata_q <= 8'h00;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_h_q     <= len_h_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_apu_rom_loader.sv
// Bench for apu_rom_loader: byte-level frame model checked every cycle, directed
// frames from the test plan with literal expectations, then randomized frames.
module tb_apu_rom_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_stb;
    logic [7:0] in_byte;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;

    apu_rom_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_stb    (in_stb),
        .in_byte   (in_byte),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: position within the frame counted in bytes since START_BYTE.
    int         m_pos;      // 0 idle, 1..4 header bytes, 5 payload, 6 checksum
    int         m_addr;
    int         m_len_h;
    int         m_left;
    logic [7:0] m_sum;
    logic       exp_we, exp_hold, exp_busy, exp_done, exp_err;
    int         exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] mdl_mem [1024];
    logic [7:0] dut_mem [1024];
    int         we_cnt = 0;
    int         done_cnt = 0;

    task automatic model_reset();
        m_pos = 0; m_addr = 0; m_len_h = 0; m_left = 0; m_sum = 8'h00;
        exp_we = 1'b0; exp_addr = 0; exp_wdata = 8'h00;
        exp_hold = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    endtask

    task automatic model_step(input logic stb, input logic [7:0] b);
        int len;
        exp_we   = 1'b0;
        exp_done = 1'b0;
        if (stb) begin
            if (m_pos == 0) begin
                if (b == 8'hA5) begin
                    m_pos = 1; exp_err = 1'b0; exp_hold = 1'b1; m_sum = 8'h00;
                end
            end else if (m_pos == 1) begin
                m_addr = (m_addr % 256) + 256 * (b % 4); m_pos = 2;
            end else if (m_pos == 2) begin
                m_addr = (m_addr / 256) * 256 + b; m_pos = 3;
            end else if (m_pos == 3) begin
                m_len_h = b % 8; m_pos = 4;
            end else if (m_pos == 4) begin
                len = m_len_h * 256 + b;
                if (len == 0 || len > 1024) begin
                    exp_err = 1'b1; m_pos = 0;
                end else begin
                    m_left = len; m_pos = 5;
                end
            end else if (m_pos == 5) begin
                exp_we = 1'b1; exp_addr = m_addr; exp_wdata = b;
                mdl_mem[m_addr] = b;
                m_addr = (m_addr + 1) % 1024;
                m_sum  = m_sum ^ b;
                m_left = m_left - 1;
                if (m_left == 0) m_pos = 6;
            end else begin
                if (b == m_sum) begin
                    exp_done = 1'b1; exp_hold = 1'b0;
                end else begin
                    exp_err = 1'b1;
                end
                m_pos = 0;
            end
        end
        exp_busy = (m_pos != 0);
    endtask

    // Inputs change 1 time unit after the active edge; the model follows each edge.
    task automatic cycle(input logic stb, input logic [7:0] b);
        in_stb  = stb;
        in_byte = b;
        @(posedge clk);
        if (!rst) model_step(stb, b);
        #1;
        in_stb = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        check("ram_we", 32'(ram_we), 32'(exp_we));
        check("ram_addr", 32'(ram_addr), 32'(exp_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(exp_wdata));
        check("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        check("error", 32'(error), 32'(exp_err));
        if (ram_we === 1'b1) begin
            dut_mem[ram_addr] = ram_wdata;
            we_cnt++;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic rand_frame();
        int         kind;
        int         a, len;
        logic [7:0] sum, b;
        logic [7:0] lh, ll;
        kind = $urandom_range(0, 9);
        if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < 3; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                send(b);
            end
        end
        a = $urandom_range(0, 1023);
        if (kind == 2) a = 1024 - $urandom_range(1, 5);
        send(8'hA5);
        send(8'({$urandom_range(0, 63), 2'b00}) | 8'(a / 256));
        send(8'(a % 256));
        if (kind == 0) begin
            lh = 8'($urandom_range(4, 7));
            ll = (lh == 8'd4) ? 8'($urandom_range(1, 255)) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin lh = 8'd0; ll = 8'd0; end
            send(lh | 8'({$urandom_range(0, 31), 3'b000}));
            send(ll);
            return;
        end
        len = $urandom_range(1, 24);
        send(8'({$urandom_range(0, 31), 3'b000}));
        send(8'(len));
        sum = 8'h00;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            if (kind == 3 && i == 0) b = 8'hA5;
            sum = sum ^ b;
            send(b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        if (kind == 1) sum = sum ^ 8'($urandom_range(1, 255));
        send(sum);
        idle($urandom_range(0, 2));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dc, wc, mism;
        for (int i = 0; i < 1024; i++) begin
            mdl_mem[i] = 8'h00;
            dut_mem[i] = 8'h00;
        end
        rst = 1'b1; in_stb = 1'b0; in_byte = 8'h00;
        model_reset();
        #23;
        check("reset ram_we", 32'(ram_we), 32'd0);
        check("reset ram_addr", 32'(ram_addr), 32'd0);
        check("reset cpu_hold", 32'(cpu_hold), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset error", 32'(error), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Good load
        dc = done_cnt;
        foreach (dc_bytes_good[i]) send(dc_bytes_good[i]);
        settle();
        check("good mem000", 32'(dut_mem[10'h000]), 32'h01);
        check("good mem001", 32'(dut_mem[10'h001]), 32'hF7);
        check("good mem002", 32'(dut_mem[10'h002]), 32'h3F);
        check("good done pulses", 32'(done_cnt - dc), 32'd1);
        check("good cpu_hold", 32'(cpu_hold), 32'd0);
        check("good error", 32'(error), 32'd0);
        idle(1);

        // Wrap-around
        foreach (dc_bytes_wrap[i]) send(dc_bytes_wrap[i]);
        settle();
        check("wrap mem3ff", 32'(dut_mem[10'h3FF]), 32'hAA);
        check("wrap mem000", 32'(dut_mem[10'h000]), 32'h55);
        check("wrap cpu_hold", 32'(cpu_hold), 32'd0);

        // Bad checksum then recovery
        dc = done_cnt;
        foreach (dc_bytes_badsum[i]) send(dc_bytes_badsum[i]);
        settle();
        check("badsum mem010", 32'(dut_mem[10'h010]), 32'h5A);
        check("badsum no done", 32'(done_cnt - dc), 32'd0);
        check("badsum error", 32'(error), 32'd1);
        check("badsum cpu_hold", 32'(cpu_hold), 32'd1);
        foreach (dc_bytes_good[i]) send(dc_bytes_good[i]);
        settle();
        check("recover error", 32'(error), 32'd0);
        check("recover cpu_hold", 32'(cpu_hold), 32'd0);

        // Bad lengths
        wc = we_cnt;
        foreach (dc_bytes_len0[i]) send(dc_bytes_len0[i]);
        settle();
        check("len0 error", 32'(error), 32'd1);
        check("len0 busy", 32'(busy), 32'd0);
        check("len0 cpu_hold", 32'(cpu_hold), 32'd1);
        foreach (dc_bytes_len1025[i]) send(dc_bytes_len1025[i]);
        settle();
        check("len1025 error", 32'(error), 32'd1);
        check("len1025 busy", 32'(busy), 32'd0);
        check("badlen writes", 32'(we_cnt - wc), 32'd0);

        // Noise and re-arm
        foreach (dc_bytes_good[i]) send(dc_bytes_good[i]);
        send(8'h00); send(8'hFF); send(8'h12);
        settle();
        check("noise busy", 32'(busy), 32'd0);
        check("noise cpu_hold", 32'(cpu_hold), 32'd0);
        send(8'hA5);
        check("rearm cpu_hold", 32'(cpu_hold), 32'd1);
        check("rearm busy", 32'(busy), 32'd1);

        // Reset mid-DATA, after 2 of 3 payload bytes
        send(8'h00); send(8'h20); send(8'h00); send(8'h03); send(8'h11); send(8'h22);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("midrst ram_we", 32'(ram_we), 32'd0);
        check("midrst ram_addr", 32'(ram_addr), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst cpu_hold", 32'(cpu_hold), 32'd1);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        wc = we_cnt;
        send(8'h33); send(8'h00);
        settle();
        check("postrst writes", 32'(we_cnt - wc), 32'd0);
        check("postrst busy", 32'(busy), 32'd0);

        // Randomized frames
        for (int f = 0; f < 80; f++) rand_frame();
        idle(3);

        mism = 0;
        for (int i = 0; i < 1024; i++) if (dut_mem[i] !== mdl_mem[i]) mism++;
        check("ram image mismatches", 32'(mism), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    logic [7:0] dc_bytes_good    [9] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01, 8'hF7, 8'h3F, 8'hC9};
    logic [7:0] dc_bytes_wrap    [8] = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'h55, 8'hFF};
    logic [7:0] dc_bytes_badsum  [7] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h5A, 8'h00};
    logic [7:0] dc_bytes_len0    [5] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] dc_bytes_len1025 [5] = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h01};

endmodule

// File: doc/apu_rom_loader.md
# apu_rom_loader

Byte-stream loader that fills the 1 KiB APU program RAM, the writable counterpart of the APU boot ROM that the APU Z80 core reads at reset. It accepts framed bytes from the host-side byte channel (AVR/SPI), writes payload bytes to sequential RAM addresses, and checks an XOR checksum. It holds the APU CPU in reset until a frame has loaded successfully. It sits between the SPI byte receiver and the write port of the program RAM; the CPU read port is untouched.

## Interface
Parameters:
- START_BYTE, 8'hA5, frame start marker recognised in IDLE
- MAX_LEN, 1024, largest legal payload length (RAM depth)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_stb  in  1  one-cycle strobe: in_byte valid; may assert every cycle
- in_byte  in  8  received byte
- ram_we  out  1  program RAM write enable (one cycle per payload byte)
- ram_addr  out  10  program RAM write address
- ram_wdata  out  8  program RAM write data
- cpu_hold  out  1  1 = keep APU Z80 in reset
- busy  out  1  frame in progress (any state other than IDLE)
- done  out  1  one-cycle pulse on good checksum
- error  out  1  sticky frame error, cleared by next START_BYTE

## Operation
- Frame format: START_BYTE, ADDR_H (bits 1:0 used, 7:2 ignored), ADDR_L, LEN_H (bits 2:0 used), LEN_L, LEN payload bytes, SUM.
- SUM = XOR of all payload bytes, seed 8'h00; header bytes are excluded.
- FSM states: IDLE -> ADDR_H -> ADDR_L -> LEN_H -> LEN_L -> DATA -> SUM -> IDLE. Each transition is taken only on in_stb.
- IDLE: bytes other than START_BYTE are ignored. START_BYTE clears error, sets cpu_hold=1 and clears the running sum.
- LEN_L: if the 11-bit length is 0 or greater than MAX_LEN, set error=1, go to IDLE, and keep cpu_hold=1. Otherwise load the remaining-count register.
- DATA: each byte is written at the current address, the address increments modulo 1024 (0x3FF wraps to 0x000), the byte is XORed into the sum, and the count decrements. Leave DATA after the last byte.
- SUM: on a match, pulse done, set cpu_hold=0, error stays 0. On a mismatch, set error=1 and cpu_hold stays 1. RAM contents already written are not rolled back.
- START_BYTE seen inside the header or DATA is treated as ordinary data; there is no resync mid-frame.
- Reset values: ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=1, busy=0, done=0, error=0, state=IDLE, sum=0, count=0.
- Reset mid-frame aborts immediately: the partial load is abandoned and cpu_hold stays 1.

## Timing
- All outputs are registered.
- Payload byte strobed at cycle n: ram_we=1 in cycle n+1 with that address and data. ram_addr/ram_wdata hold their value otherwise.
- SUM byte strobed at cycle n: done pulses in cycle n+1, and cpu_hold falls in cycle n+1.
- busy rises the cycle after START_BYTE is accepted. It falls the cycle after the SUM byte or after a length error.
- Back-to-back strobes every cycle are supported; throughput is one RAM write per cycle.
- cpu_hold rises the cycle after any accepted START_BYTE, even if a previous load succeeded.

## Test plan
- Good load: A5 00 00 00 03 01 F7 3F C9 -> writes 000=01, 001=F7, 002=3F on three consecutive ram_we cycles; done pulses once; cpu_hold 1->0; error=0.
- Wrap-around: A5 03 FF 00 02 AA 55 FF -> writes 3FF=AA then 000=55; done pulses; cpu_hold=0.
- Bad checksum: A5 00 10 00 01 5A 00 -> write 010=5A; no done pulse; error=1; cpu_hold=1. A following good frame clears error and releases cpu_hold.
- Bad length: A5 00 00 00 00, then A5 00 00 04 01 -> error=1 after each LEN_L; no ram_we; FSM back in IDLE; cpu_hold=1.
- Noise and re-arm: bytes 00 FF 12 in IDLE -> ignored with no state change. Then a good frame, then a single A5 -> cpu_hold returns to 1 and busy=1.
- Reset mid-DATA: assert rst after 2 of 3 payload bytes -> outputs take reset values asynchronously; the next bytes without a START_BYTE produce no writes.
